candidate_scanner: RTL
======================

CANDIDATE_SCANNER -- requirements
Module: candidate_scanner

Interface
REQ-001 SHALL have parameter NUM_WINDOWS, default 1024, number of countBus entries scanned.
REQ-002 SHALL have parameter COUNT_W, default 32, width of each count, threshold and ID.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset is synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to scan countBus.
REQ-006 SHALL have port threshold  input  COUNT_W  minimum count for a window to be a candidate.
REQ-007 SHALL have port countBus  input  [0:NUM_WINDOWS-1] x COUNT_W  per-window vote counts from the hash table.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port cand_valid  output  1  candidate stream valid.
REQ-010 SHALL have port cand_ready  input  1  candidate stream ready from the consumer.
REQ-011 SHALL have port cand_id  output  COUNT_W  window index of the candidate.
REQ-012 SHALL have port cand_count  output  COUNT_W  count of the candidate.
REQ-013 SHALL have port done  output  1  one-cycle pulse at scan end.
REQ-014 SHALL have port num_cand  output  log2(NUM_WINDOWS)+1  candidates emitted in the last scan.
REQ-015 SHALL have ports best_id / best_count  output  COUNT_W each  highest-count window of the last scan.

Function
REQ-016 SHALL implement states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start; SCAN->DRAIN after index NUM_WINDOWS-1 is evaluated; DRAIN->DONE when the output register is empty or accepted that cycle; DONE->IDLE unconditionally.
REQ-017 SHALL sample threshold on the accepted start edge; later threshold changes do not affect the running scan.
REQ-018 SHALL ignore start when not in IDLE.
REQ-019 SHALL evaluate one window per cycle in SCAN, index ascending from 0, only when the output register is empty or being accepted that cycle; otherwise hold the index (stall).
REQ-020 SHALL load the output register with {index, countBus[index]} when countBus[index] >= threshold (unsigned); cand_valid rises the cycle after evaluation.
REQ-021 SHALL hold cand_id, cand_count, cand_valid stable while cand_valid=1 and cand_ready=0; transfer occurs on cand_valid & cand_ready.
REQ-022 SHALL increment num_cand on each transfer; cleared at accepted start, held after done.
REQ-023 SHALL, with cand_ready held 1 and no stalls, pulse done exactly NUM_WINDOWS+2 cycles after the start edge.
REQ-024 SHALL not wrap the index; evaluation stops at NUM_WINDOWS-1.
REQ-025 SHALL rely on countBus being stable while busy=1; upstream guarantees no insert/query during a scan.
REQ-026 SHALL emit nothing and pulse done with num_cand=0 when no count meets threshold.

Reset
REQ-027 SHALL, when reset=0 at a clock edge, enter IDLE and drive busy, cand_valid, done to 0 and cand_id, cand_count, num_cand, best_id, best_count to 0.
REQ-028 SHALL abort a scan in progress on reset and discard any pending candidate without transfer.

Configuration
REQ-029 SHALL, with macro CAND_BEST_MATCH_EN defined, track best_id/best_count across evaluated candidates: strictly greater count replaces; ties keep lower index; values cleared at start, final at done.
REQ-030 SHALL, without CAND_BEST_MATCH_EN, tie best_id and best_count to 0 and synthesise no tracking logic.

Structure
REQ-031 SHALL take NUM_WINDOWS, COUNT_W defaults and the state enum typedef from shared package lsh_pkg.
REQ-032 SHALL be a single module; no sub-module; output register implemented inline.

Verification
REQ-033 SHALL cover: counts[5]=3, counts[900]=7, rest 0, threshold=2, ready=1 -> candidates (5,3) then (900,7), num_cand=2, best=(900,7), done at start+1026.
REQ-034 SHALL cover: same stimulus, cand_ready=0 for 20 cycles after first cand_valid -> (5,3) held stable, no index advance, done delayed 20 cycles, num_cand=2.
REQ-035 SHALL cover: all counts 0, threshold=1 -> no cand_valid, done pulses, num_cand=0, best=(0,0).
REQ-036 SHALL cover: counts[10]=4, counts[20]=4, threshold=0 -> 1024 candidates, num_cand=1024, best=(10,4) with CAND_BEST_MATCH_EN, (0,0) without.
REQ-037 SHALL cover: reset=0 asserted at scan index 300 with cand_valid pending -> next cycle IDLE, cand_valid=0, busy=0, no done pulse.
REQ-038 SHALL cover: second start and threshold change while busy -> ignored, scan completes with original threshold.

Source files
------------

// File: rtl/lsh_pkg.sv
// Shared LSH definitions: default sizes and scanner state type.
`timescale 1ns/1ps
package lsh_pkg;

  localparam int NUM_WINDOWS_DEF = 1024;
  localparam int COUNT_W_DEF     = 32;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/candidate_scanner.sv
// Scans countBus for windows at or above threshold and streams them out.
// Optional best-match tracking is enabled with macro CAND_BEST_MATCH_EN.
`timescale 1ns/1ps
module candidate_scanner
  import lsh_pkg::*;
#(
  parameter int NUM_WINDOWS = NUM_WINDOWS_DEF,
  parameter int COUNT_W     = COUNT_W_DEF,
  localparam int IDX_W      = idx_w(NUM_WINDOWS),
  localparam int NC_W       = $clog2(NUM_WINDOWS) + 1
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] threshold,
  input  logic [COUNT_W-1:0] countBus [0:NUM_WINDOWS-1],
  output logic               busy,
  output logic               cand_valid,
  input  logic               cand_ready,
  output logic [COUNT_W-1:0] cand_id,
  output logic [COUNT_W-1:0] cand_count,
  output logic               done,
  output logic [NC_W-1:0]    num_cand,
  output logic [COUNT_W-1:0] best_id,
  output logic [COUNT_W-1:0] best_count
);

  scan_state_t        state;
  logic [IDX_W-1:0]   idx;
  logic [COUNT_W-1:0] thr;
  logic [COUNT_W-1:0] cur;
  logic               xfer;
  logic               can_eval;
  logic               hit;
  logic               last;

  assign xfer     = cand_valid & cand_ready;
  assign can_eval = ~cand_valid | cand_ready;
  assign cur      = countBus[idx];
  assign hit      = cur >= thr;
  assign last     = idx == IDX_W'(NUM_WINDOWS - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      thr        <= '0;
      busy       <= 1'b0;
      cand_valid <= 1'b0;
      cand_id    <= '0;
      cand_count <= '0;
      done       <= 1'b0;
      num_cand   <= '0;
    end else begin
      done <= 1'b0;
      if (xfer) begin
        cand_valid <= 1'b0;
        num_cand   <= num_cand + NC_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            idx      <= '0;
            thr      <= threshold;
            num_cand <= '0;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          // Stall the index while an unaccepted candidate occupies the slot.
          if (can_eval) begin
            if (hit) begin
              cand_valid <= 1'b1;
              cand_id    <= COUNT_W'(idx);
              cand_count <= cur;
            end
            if (last) state <= DRAIN;
            else idx <= idx + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (can_eval) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CAND_BEST_MATCH_EN
  logic eval;

  assign eval = (state == SCAN) & can_eval;

  // Strict compare keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (!reset) begin
      best_id    <= '0;
      best_count <= '0;
    end else if (state == IDLE && start) begin
      best_id    <= '0;
      best_count <= '0;
    end else if (eval && hit && cur > best_count) begin
      best_id    <= COUNT_W'(idx);
      best_count <= cur;
    end
  end
`else
  assign best_id    = '0;
  assign best_count = '0;
`endif

endmodule
